mem_arbiter: RTL

- Shares the single-port 1024x16 main memory between two requesters: port 0 (instruction fetch) and port 1 (load/store data).
- Sits between the CPU control unit and the memory block, and owns that block's MemRead, MemWrite, ADDR and Data_in.
- The memory performs an access on the clock edge where a strobe is high; read data appears on Data_out after that edge.
- The arbiter serialises one transaction at a time, using round-robin or fixed priority, with a req/ack handshake and out-of-range address rejection.

---
 rtl/cpu_mem_pkg.sv | 15 +
 rtl/mem_arbiter_if.sv | 30 +++
 rtl/mem_arbiter_rr_arb2.sv | 18 +
 rtl/mem_arbiter.sv | 90 +++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared constants for the CPU memory subsystem: data width, memory depth
// and the arbiter FSM state encoding.
package cpu_mem_pkg;

  localparam int DATA_W    = 16;
  localparam int MEM_WORDS = 1024;

  typedef logic [DATA_W-1:0] word_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports plus the memory-side strobes, address and data.
interface mem_arbiter_if;
  import cpu_mem_pkg::*;

  logic  req0, we0, ack0, err0;
  word_t addr0, wdata0, rdata0;
  logic  req1, we1, ack1, err1;
  word_t addr1, wdata1, rdata1;
  logic  mem_read, mem_write, busy;
  word_t mem_addr, mem_wdata, mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata,
    output ack0, rdata0, err0,
    output ack1, rdata1, err1,
    output mem_read, mem_write, mem_addr, mem_wdata, busy
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rdata,
    input  ack0, rdata0, err0,
    input  ack1, rdata1, err1,
    input  mem_read, mem_write, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way picker; the round-robin pointer lives in the caller.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_lastGnt,
  input  logic       i_fixedPri,
  output logic       o_gntId
);

  always_comb begin
    o_gntId = 1'b0;
    case (i_req)
      2'b10:   o_gntId = 1'b1;
      2'b11:   o_gntId = i_fixedPri ? 1'b1 : ~i_lastGnt;
      default: o_gntId = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch (port 0) and load/store (port 1) accesses onto
// the single-port main memory, one transaction at a time.
module mem_arbiter #(
  parameter int MEM_WORDS = cpu_mem_pkg::MEM_WORDS,
  parameter bit FIXED_PRI = 1'b0
) (
  input logic          CLK,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  import cpu_mem_pkg::*;

  localparam logic [DATA_W:0] LP_LIMIT = 17'(MEM_WORDS);

  logic [1:0] r_state;
  logic       r_gntId, r_lastGnt, r_we, r_err;
  word_t      r_addr, r_wdata, r_rdata0, r_rdata1;

  logic       w_gntId, w_selWe, w_inRange, w_issue, w_done;
  word_t      w_selAddr, w_selWdata;

  rr_arb2 u_pick (
    .i_req      ({bus.req1, bus.req0}),
    .i_lastGnt  (r_lastGnt),
    .i_fixedPri (FIXED_PRI),
    .o_gntId    (w_gntId)
  );

  assign w_selWe    = w_gntId ? bus.we1    : bus.we0;
  assign w_selAddr  = w_gntId ? bus.addr1  : bus.addr0;
  assign w_selWdata = w_gntId ? bus.wdata1 : bus.wdata0;
  // Full 16-bit compare so high addresses never alias into the array.
  assign w_inRange  = {1'b0, w_selAddr} < LP_LIMIT;

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_gntId   <= 1'b0;
      r_lastGnt <= 1'b1;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req0 || bus.req1) begin
            r_gntId   <= w_gntId;
            r_lastGnt <= w_gntId;
            r_we      <= w_selWe;
            r_addr    <= w_selAddr;
            r_wdata   <= w_selWdata;
            r_err     <= ~w_inRange;
            r_state   <= w_inRange ? ST_ISSUE : ST_DONE;
          end
        end
        ST_ISSUE: r_state <= r_we ? ST_DONE : ST_WAIT;
        ST_WAIT: begin
          if (r_gntId) r_rdata1 <= bus.mem_rdata;
          else         r_rdata0 <= bus.mem_rdata;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobes and acks are masked by reset so an abort never strobes or completes.
  assign w_issue = (r_state == ST_ISSUE) && !reset;
  assign w_done  = (r_state == ST_DONE)  && !reset;

  assign bus.mem_read  = w_issue && !r_we;
  assign bus.mem_write = w_issue &&  r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.ack0      = w_done && !r_gntId;
  assign bus.ack1      = w_done &&  r_gntId;
  assign bus.err0      = w_done && !r_gntId && r_err;
  assign bus.err1      = w_done &&  r_gntId && r_err;
  assign bus.rdata0    = r_rdata0;
  assign bus.rdata1    = r_rdata1;

endmodule
